apb_slv_mem: RTL and testbench
==============================

Name: apb_slv_mem

Overview:
- Synthesizable APB4 completer that sits directly downstream of the APB master interface and consumes its PSEL/PENABLE/PADDR/PWDATA/PWRITE/PSTROB/PPROT.
- Produces PREADY/PRDATA/PSLVERR.
- Backs accesses with an internal word-addressed register memory and inserts a programmable number of wait states.
- Flags decode errors and protocol violations; serves as the DUT/reference slave for the master VIP.

Parameters:
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width (8/16/32)
- STRB_WIDTH, DATA_WIDTH/8, PSTROB width
- MEM_DEPTH, 256, number of DATA_WIDTH words (power of 2)
- BASE_ADDR, 0, byte address of word 0

Ports:
- clk  in  1  APB clock (PCLK)
- rstn  in  1  asynchronous active-low reset (PRESETn)
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PWRITE  in  1  1=write, 0=read
- PSTROB  in  STRB_WIDTH  write byte strobes
- PPROT  in  3  protection type
- PREADY  out  1  transfer complete
- PRDATA  out  DATA_WIDTH  read data
- PSLVERR  out  1  transfer error, valid only with PREADY
- cfg_wait_i  in  4  wait states per transfer, sampled in setup phase
- proto_err_o  out  1  one-cycle pulse on protocol violation
- err_cnt_o  out  16  saturating count of PSLVERR completions

Behaviour:
- Reset (async on rstn low, any state):
  - PREADY=0, PRDATA=0, PSLVERR=0, proto_err_o=0, err_cnt_o=0.
  - FSM returns to IDLE, all memory words cleared to 0.
  - An in-flight transfer is discarded with no memory update.
- FSM states: IDLE, WAIT, DONE. All outputs are registered.
- IDLE:
  - PSEL=1 & PENABLE=0 sampled → latch addr/write/wdata/strobe, load wcnt=cfg_wait_i.
  - If cfg_wait_i=0: go to DONE and set PREADY=1 for the next cycle. Else go to WAIT.
  - PSEL=1 & PENABLE=1 sampled with no prior setup → proto_err_o pulse, stay IDLE.
- WAIT:
  - Each cycle with PSEL=1 & PENABLE=1: wcnt decrements. When wcnt reaches 1, go to DONE with PREADY=1 registered.
  - Latency: PREADY is high in access cycle N+1 for N=cfg_wait_i, so total transfer = N+2 cycles.
- DONE:
  - PREADY=1 for exactly one cycle; the transfer completes at the edge ending this cycle; next state IDLE, PREADY→0.
  - Back-to-back setup in the following cycle is accepted with no extra idle cycle.
- Abort:
  - In WAIT or DONE, sampling PSEL=0 or PENABLE=0 → proto_err_o pulse, return IDLE.
  - No memory write, PREADY/PSLVERR forced 0.
  - Latched address/control are NOT re-checked against live bus values (PADDR changes are ignored).
- Decode, with idx=(PADDR-BASE_ADDR)>>log2(STRB_WIDTH). Error if any of:
  - PADDR<BASE_ADDR
  - idx>=MEM_DEPTH
  - PADDR[log2(STRB_WIDTH)-1:0]!=0
- Write completion:
  - No error: mem[idx] byte lane b updated iff PSTROB[b]=1.
  - PSTROB=0 is a legal no-op write.
- Read completion:
  - No error: PRDATA=mem[idx], registered alongside PREADY.
  - PSTROB ignored for reads.
  - PRDATA=0 whenever PREADY=0.
- Error completion: PSLVERR=1 with PREADY, PRDATA=0, no memory update.
- err_cnt_o: increments on every PSLVERR completion; saturates at 16'hFFFF. Aborts do not count.
- cfg_wait_i changes mid-transfer have no effect on the current transfer.

Optional Feature:
- APB_SLV_PPROT_CHK_EN defined:
  - Transfers with PPROT[1]=1 (non-secure) to idx>=MEM_DEPTH/2 complete with PSLVERR=1, PRDATA=0, no write, err_cnt_o incremented.
  - Lower half is unrestricted.
- Undefined: PPROT is ignored entirely.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 with PSTROB=4'hF, cfg_wait_i=0, then read 0x10 → write PREADY in 2nd cycle, PSLVERR=0; read PRDATA=0xDEADBEEF.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD with PSTROB=4'b0101, then read 0x20 → PRDATA=0x11BB33DD.
- cfg_wait_i=3, read 0x10 → PREADY low for 3 access cycles, high in the 4th; transfer spans 5 clocks.
- Read 0x400 (idx 256), then write 0x02 (unaligned) → both PSLVERR=1, PRDATA=0, err_cnt_o=2, memory unchanged.
- cfg_wait_i=5, drop PSEL in 2nd wait cycle → proto_err_o single pulse, no PREADY, mem unchanged; next normal transfer completes.
- Assert rstn low mid-WAIT after mem[4]=0x55 → outputs 0 immediately; read 0x10 after release returns 0. With APB_SLV_PPROT_CHK_EN defined: PPROT=3'b010 write to 0x200 → PSLVERR=1.

Source files
------------

// File: rtl/apb_slv_mem.sv
// APB4 completer backed by a word register memory with programmable wait states.
// Define APB_SLV_PPROT_CHK_EN to reject non-secure accesses to the upper half.
module apb_slv_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PWRITE,
  input  logic [STRB_WIDTH-1:0] PSTROB,
  input  logic [2:0]            PPROT,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  input  logic [3:0]            cfg_wait_i,
  output logic                  proto_err_o,
  output logic [15:0]           err_cnt_o
);

  localparam int LSB = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_M = ADDR_WIDTH'(STRB_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]            state;
  logic [3:0]            wcnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  write_q;

  logic                  setup;
  logic                  access;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_write;
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word;
  logic [IW-1:0]         idx;
  logic                  dec_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  mem_wr;

  assign setup  = PSEL & ~PENABLE;
  assign access = PSEL & PENABLE;

  // Zero-wait transfers decode straight off the bus in setup phase
  assign cur_addr  = (state == S_IDLE) ? PADDR  : addr_q;
  assign cur_write = (state == S_IDLE) ? PWRITE : write_q;

  assign off  = cur_addr - BASE_ADDR;
  assign word = off >> LSB;
  assign idx  = word[IW-1:0];

`ifdef APB_SLV_PPROT_CHK_EN
  logic prot_q;
  logic cur_ns;
  assign cur_ns = (state == S_IDLE) ? PPROT[1] : prot_q;
  assign dec_err = (cur_addr < BASE_ADDR)
                 | (word >= DEPTH_A)
                 | ((cur_addr & ALIGN_M) != '0)
                 | (cur_ns & (word >= (DEPTH_A >> 1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prot_q <= 1'b0;
    end else if (state == S_IDLE && setup) begin
      prot_q <= PPROT[1];
    end
  end
`else
  logic unused_prot;
  assign unused_prot = ^PPROT;
  assign dec_err = (cur_addr < BASE_ADDR)
                 | (word >= DEPTH_A)
                 | ((cur_addr & ALIGN_M) != '0);
`endif

  assign rd_data = (!dec_err && !cur_write) ? mem[idx] : '0;
  assign mem_wr  = (state == S_DONE) & access & write_q & ~dec_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      write_q     <= 1'b0;
      PREADY      <= 1'b0;
      PRDATA      <= '0;
      PSLVERR     <= 1'b0;
      proto_err_o <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      proto_err_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (setup) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            strb_q  <= PSTROB;
            write_q <= PWRITE;
            wcnt    <= cfg_wait_i;
            if (cfg_wait_i == 4'd0) begin
              state   <= S_DONE;
              PREADY  <= 1'b1;
              PSLVERR <= dec_err;
              PRDATA  <= rd_data;
            end else begin
              state <= S_WAIT;
            end
          end else if (access) begin
            proto_err_o <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!access) begin
            state       <= S_IDLE;
            proto_err_o <= 1'b1;
          end else if (wcnt == 4'd1) begin
            state   <= S_DONE;
            PREADY  <= 1'b1;
            PSLVERR <= dec_err;
            PRDATA  <= rd_data;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
          if (!access) begin
            proto_err_o <= 1'b1;
          end else if (PSLVERR && err_cnt_o != 16'hFFFF) begin
            err_cnt_o <= err_cnt_o + 16'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_wr) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (strb_q[b]) begin
          mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slv_mem.sv
// Self-checking bench for apb_slv_mem against a word-array reference model.
// Same APB_SLV_PPROT_CHK_EN define as the design selects the PPROT rule.
module tb_apb_slv_mem;

  logic        clk;
  logic        rstn;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic [3:0]  PSTROB;
  logic [2:0]  PPROT;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic [3:0]  cfg_wait;
  logic        proto_err;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [256];
  int unsigned err_m;

  apb_slv_mem dut (
    .clk         (clk),
    .rstn        (rstn),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PWRITE      (PWRITE),
    .PSTROB      (PSTROB),
    .PPROT       (PPROT),
    .PREADY      (PREADY),
    .PRDATA      (PRDATA),
    .PSLVERR     (PSLVERR),
    .cfg_wait_i  (cfg_wait),
    .proto_err_o (proto_err),
    .err_cnt_o   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    err_m = 0;
  endtask

  // Reference: byte address -> word index, error rules, byte-lane merge
  task automatic model(input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [2:0] p,
                       output logic [31:0] er, output logic ee);
    int unsigned wi;
    wi = a / 4;
    ee = (a % 4 != 0) || (a / 4 >= 256);
`ifdef APB_SLV_PPROT_CHK_EN
    if (p[1] && wi >= 128) ee = 1'b1;
`else
    if (p[1] && wi >= 1024) ee = 1'b1;
`endif
    er = 32'h0;
    if (ee) begin
      if (err_m < 65535) err_m++;
    end else if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mem_m[wi][8*b +: 8] = d[8*b +: 8];
    end else begin
      er = mem_m[wi];
    end
  endtask

  // Starts right after a rising edge; returns right after a rising edge
  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p, input logic [3:0] n,
                      output logic [31:0] rd, output logic err,
                      output int acc);
    bit done;
    int guard;
    cfg_wait = n;
    PSEL = 1'b1; PENABLE = 1'b0;
    PADDR = a; PWRITE = w; PWDATA = d; PSTROB = s; PPROT = p;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    cfg_wait = 4'($urandom);
    acc = 0; rd = 32'h0; err = 1'b0; done = 0; guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      acc++; guard++;
      if (PREADY) begin
        rd = PRDATA; err = PSLVERR; done = 1;
      end else begin
        checks++;
        if (PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: PRDATA=%h PSLVERR=%b, required 0/0",
                   PRDATA, PSLVERR);
        end
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL ready_timeout: no PREADY after %0d cycles, addr=%h", guard, a);
    end
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int acc;
    rstn = 1'b0; PSEL = 0; PENABLE = 0; PADDR = 0; PWDATA = 0;
    PWRITE = 0; PSTROB = 0; PPROT = 0; cfg_wait = 0;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if ({PREADY, PSLVERR, proto_err} !== 3'b000 || PRDATA !== 32'h0 || err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b err=%b pe=%b rd=%h cnt=%h, required all 0",
               PREADY, PSLVERR, proto_err, PRDATA, err_cnt);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    xfer(32'h3FC, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, rd, err, acc);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem: got %h/%b, required 0/0", rd, err);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd, er; logic err, ee; int acc;
    xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0, rd, err, acc);
    model(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, er, ee);
    checks++;
    if (acc !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_write: acc_cycles=%0d err=%b, required 1/0", acc, err);
    end
    xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, rd, err, acc);
    checks++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_read: got %h/%b, required deadbeef/0", rd, err);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd, er; logic err, ee; int acc;
    xfer(32'h20, 1'b1, 32'h11223344, 4'hF, 3'b000, 4'd0, rd, err, acc);
    model(32'h20, 1'b1, 32'h11223344, 4'hF, 3'b000, er, ee);
    xfer(32'h20, 1'b1, 32'hAABBCCDD, 4'b0101, 3'b000, 4'd1, rd, err, acc);
    model(32'h20, 1'b1, 32'hAABBCCDD, 4'b0101, 3'b000, er, ee);
    xfer(32'h20, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, rd, err, acc);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe_merge: got %h, required 11bb33dd", rd);
    end
  endtask

  task automatic test_wait();
    logic [31:0] rd; logic err; int acc;
    xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 4'd3, rd, err, acc);
    checks++;
    if (acc !== 4 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wait3: acc_cycles=%0d rd=%h, required 4/deadbeef", acc, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, er; logic err, ee; int acc;
    logic [15:0] c0;
    c0 = err_cnt;
    xfer(32'h400, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, rd, err, acc);
    model(32'h400, 1'b0, 32'h0, 4'h0, 3'b000, er, ee);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oob_read: err=%b rd=%h, required 1/0", err, rd);
    end
    xfer(32'h02, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, 4'd2, rd, err, acc);
    model(32'h02, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, er, ee);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL unaligned_write: err=%b rd=%h, required 1/0", err, rd);
    end
    checks++;
    if (err_cnt !== c0 + 16'd2) begin
      errors++;
      $display("FAIL err_count: got %0d, required %0d", err_cnt, c0 + 16'd2);
    end
    xfer(32'h0, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, rd, err, acc);
    checks++;
    if (rd !== mem_m[0] || err !== 1'b0) begin
      errors++;
      $display("FAIL err_no_write: got %h/%b, required %h/0", rd, err, mem_m[0]);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int acc;
    int pulses, rdy;
    cfg_wait = 4'd5;
    PSEL = 1; PENABLE = 0; PADDR = 32'h30; PWRITE = 1;
    PWDATA = $urandom | 32'h1; PSTROB = 4'hF; PPROT = 0;
    @(posedge clk); #1;
    PENABLE = 1;
    @(posedge clk); #1;
    PSEL = 0; PENABLE = 0;
    pulses = 0; rdy = 0;
    repeat (4) begin
      @(negedge clk);
      if (proto_err) pulses++;
      if (PREADY) rdy++;
    end
    checks++;
    if (pulses !== 1 || rdy !== 0) begin
      errors++;
      $display("FAIL abort_pulse: pulses=%0d ready=%0d, required 1/0", pulses, rdy);
    end
    @(posedge clk); #1;
    xfer(32'h30, 1'b0, 32'h0, 4'h0, 3'b000, 4'd1, rd, err, acc);
    checks++;
    if (rd !== mem_m[12] || err !== 1'b0 || acc !== 2) begin
      errors++;
      $display("FAIL abort_recover: rd=%h err=%b acc=%0d, required %h/0/2",
               rd, err, acc, mem_m[12]);
    end
    PSEL = 1; PENABLE = 1;
    @(posedge clk); #1;
    PSEL = 0; PENABLE = 0;
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL idle_access: proto_err=%b, required 1", proto_err);
    end
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_access_len: proto_err=%b, required 0", proto_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, er; logic w, err, ee; logic [3:0] s, n;
    logic [2:0] p; int acc;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 255)) * 4;
      else a = 32'($urandom_range(0, 32'h7FF));
      w = 1'($urandom);
      d = $urandom;
      s = 4'($urandom);
      p = 3'($urandom);
      n = 4'($urandom_range(0, 3));
      xfer(a, w, d, s, p, n, rd, err, acc);
      model(a, w, d, s, p, er, ee);
      checks++;
      if (rd !== er || err !== ee || acc !== int'(n) + 1) begin
        errors++;
        $display("FAIL random[%0d] a=%h w=%b: rd=%h err=%b acc=%0d, required %h/%b/%0d",
                 k, a, w, rd, err, acc, er, ee, int'(n) + 1);
      end
      checks++;
      if (err_cnt !== 16'(err_m)) begin
        errors++;
        $display("FAIL random_cnt[%0d]: got %0d, required %0d", k, err_cnt, err_m);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd, er; logic err, ee; int acc;
    xfer(32'h10, 1'b1, 32'h55, 4'hF, 3'b000, 4'd0, rd, err, acc);
    model(32'h10, 1'b1, 32'h55, 4'hF, 3'b000, er, ee);
    xfer(32'h7FF, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, rd, err, acc);
    model(32'h7FF, 1'b0, 32'h0, 4'h0, 3'b000, er, ee);
    cfg_wait = 4'd5;
    PSEL = 1; PENABLE = 0; PADDR = 32'h10; PWRITE = 1;
    PWDATA = 32'hAA; PSTROB = 4'hF; PPROT = 0;
    @(posedge clk); #1;
    PENABLE = 1;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({PREADY, PSLVERR, proto_err} !== 3'b000 || PRDATA !== 32'h0 || err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b err=%b pe=%b rd=%h cnt=%0d, required all 0",
               PREADY, PSLVERR, proto_err, PRDATA, err_cnt);
    end
    PSEL = 0; PENABLE = 0;
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, rd, err, acc);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_mem: got %h/%b, required 0/0", rd, err);
    end
  endtask

  task automatic test_pprot();
    logic [31:0] rd, er; logic err, ee; int acc;
    xfer(32'h200, 1'b1, 32'h12345678, 4'hF, 3'b010, 4'd0, rd, err, acc);
    model(32'h200, 1'b1, 32'h12345678, 4'hF, 3'b010, er, ee);
    checks++;
    if (err !== ee) begin
      errors++;
      $display("FAIL pprot_upper: err=%b, required %b", err, ee);
    end
    xfer(32'h1FC, 1'b1, 32'hCAFEF00D, 4'hF, 3'b010, 4'd1, rd, err, acc);
    model(32'h1FC, 1'b1, 32'hCAFEF00D, 4'hF, 3'b010, er, ee);
    xfer(32'h200, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0, rd, err, acc);
    model(32'h200, 1'b0, 32'h0, 4'h0, 3'b000, er, ee);
    checks++;
    if (rd !== er || err !== 1'b0) begin
      errors++;
      $display("FAIL pprot_secure_read: got %h/%b, required %h/0", rd, err, er);
    end
    xfer(32'h1FC, 1'b0, 32'h0, 4'h0, 3'b010, 4'd0, rd, err, acc);
    checks++;
    if (rd !== 32'hCAFEF00D || err !== 1'b0) begin
      errors++;
      $display("FAIL pprot_lower: got %h/%b, required cafef00d/0", rd, err);
    end
    checks++;
    if (err_cnt !== 16'(err_m)) begin
      errors++;
      $display("FAIL pprot_cnt: got %0d, required %0d", err_cnt, err_m);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_wait();
    test_errors();
    test_abort();
    test_random();
    test_pprot();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
